// File: rtl/rtc_timekeeper.sv
// Real-time-clock core: prescales clk to a once-per-second tick and keeps hours:mins:secs,
// with run enable, range-checked time load, optional hour wrap with day pulse and a sticky alarm.
module rtc_timekeeper #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int HOURS_W       = 16,
    parameter int HOUR_MOD      = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               set_stb,
    input  logic [HOURS_W-1:0] set_hours,
    input  logic [7:0]         set_mins,
    input  logic [7:0]         set_secs,
    output logic               set_ack,
    output logic               set_err,
    input  logic               alarm_wr,
    input  logic [HOURS_W-1:0] alarm_hours,
    input  logic [7:0]         alarm_mins,
    input  logic [7:0]         alarm_secs,
    input  logic               alarm_en,
    input  logic               alarm_clr,
    output logic [HOURS_W-1:0] hours,
    output logic [7:0]         mins,
    output logic [7:0]         secs,
    output logic               sec_tick,
    output logic               day_tick,
    output logic               alarm_irq
);

    localparam int PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int P_LAST_I  = TICKS_PER_SEC - 1;
    localparam logic [PW-1:0] P_LAST = P_LAST_I[PW-1:0];

    // Free-running hours behave as a modulus of 2**HOURS_W, so one wrap value serves both modes.
    localparam int H_MOD_I   = (HOUR_MOD == 0) ? (1 << HOURS_W) : HOUR_MOD;
    localparam int H_LAST_I  = H_MOD_I - 1;
    localparam logic [HOURS_W:0]   H_MOD  = H_MOD_I[HOURS_W:0];
    localparam logic [HOURS_W-1:0] H_LAST = H_LAST_I[HOURS_W-1:0];

    logic [PW-1:0]      pcnt;
    logic [HOURS_W-1:0] a_hours;
    logic [7:0]         a_mins;
    logic [7:0]         a_secs;

    logic               load_ok;
    logic               do_load;
    logic               tick;
    logic               secs_wrap;
    logic               mins_wrap;
    logic               hours_wrap;
    logic [HOURS_W-1:0] n_hours;
    logic [7:0]         n_mins;
    logic [7:0]         n_secs;
    logic               alarm_hit;

    always_comb begin
        load_ok    = (set_secs <= 8'd59) && (set_mins <= 8'd59) && ({1'b0, set_hours} < H_MOD);
        do_load    = set_stb && load_ok;
        tick       = en && (pcnt == P_LAST);
        secs_wrap  = (secs == 8'd59);
        mins_wrap  = (mins == 8'd59);
        hours_wrap = (hours == H_LAST);

        n_secs  = secs_wrap ? 8'd0 : secs + 8'd1;
        n_mins  = mins;
        n_hours = hours;
        if (secs_wrap) begin
            n_mins = mins_wrap ? 8'd0 : mins + 8'd1;
            if (mins_wrap)
                n_hours = hours_wrap ? '0 : hours + HOURS_W'(1);
        end

        // Alarm compares against the time about to become visible, not the current one.
        alarm_hit = alarm_en && ({n_hours, n_mins, n_secs} == {a_hours, a_mins, a_secs});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt      <= '0;
            hours     <= '0;
            mins      <= '0;
            secs      <= '0;
            a_hours   <= '0;
            a_mins    <= '0;
            a_secs    <= '0;
            sec_tick  <= 1'b0;
            day_tick  <= 1'b0;
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
            alarm_irq <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle; later non-blocking assignments in this block win.
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
            set_ack  <= 1'b0;
            set_err  <= 1'b0;

            if (alarm_wr) begin
                a_hours <= alarm_hours;
                a_mins  <= alarm_mins;
                a_secs  <= alarm_secs;
            end

            if (do_load) begin
                hours   <= set_hours;
                mins    <= set_mins;
                secs    <= set_secs;
                pcnt    <= '0;
                set_ack <= 1'b1;
            end else begin
                set_err <= set_stb;
                if (tick) begin
                    pcnt     <= '0;
                    hours    <= n_hours;
                    mins     <= n_mins;
                    secs     <= n_secs;
                    sec_tick <= 1'b1;
                    day_tick <= secs_wrap && mins_wrap && hours_wrap;
                end else if (en) begin
                    pcnt <= pcnt + PW'(1);
                end
            end

            // A new match takes priority over a clear issued in the same cycle.
            if (tick && !do_load && alarm_hit)
                alarm_irq <= 1'b1;
            else if (alarm_clr)
                alarm_irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Scoreboard bench for rtc_timekeeper: directed stimulus pushes expected events (cycle, kind, time),
// per-DUT monitors pop and compare whenever sec_tick / set_ack / set_err is presented.
module tb_rtc_timekeeper;

    localparam logic [2:0] K_TICK = 3'b100;
    localparam logic [2:0] K_ACK  = 3'b010;
    localparam logic [2:0] K_ERR  = 3'b001;

    typedef struct {
        int          cyc;
        logic [2:0]  kind;
        logic [15:0] h;
        logic [7:0]  m;
        logic [7:0]  s;
        logic        day;
        logic        irq;
    } ev_t;

    ev_t q[$];
    ev_t fq[$];
    ev_t me;
    ev_t fe;
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    logic        clk;
    logic        rst;
    logic        en, set_stb, alarm_wr, alarm_en, alarm_clr;
    logic [15:0] set_hours, alarm_hours, hours;
    logic [7:0]  set_mins, set_secs, alarm_mins, alarm_secs, mins, secs;
    logic        set_ack, set_err, sec_tick, day_tick, alarm_irq;

    logic        f_en, f_set_stb;
    logic [3:0]  f_set_hours, f_hours;
    logic [7:0]  f_set_mins, f_set_secs, f_mins, f_secs;
    logic        f_set_ack, f_set_err, f_sec_tick, f_day_tick, f_alarm_irq;

    rtc_timekeeper #(.TICKS_PER_SEC(4), .HOURS_W(16), .HOUR_MOD(24)) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .set_stb(set_stb), .set_hours(set_hours), .set_mins(set_mins), .set_secs(set_secs),
        .set_ack(set_ack), .set_err(set_err),
        .alarm_wr(alarm_wr), .alarm_hours(alarm_hours), .alarm_mins(alarm_mins),
        .alarm_secs(alarm_secs), .alarm_en(alarm_en), .alarm_clr(alarm_clr),
        .hours(hours), .mins(mins), .secs(secs),
        .sec_tick(sec_tick), .day_tick(day_tick), .alarm_irq(alarm_irq)
    );

    rtc_timekeeper #(.TICKS_PER_SEC(4), .HOURS_W(4), .HOUR_MOD(0)) u_free (
        .clk(clk), .rst(rst), .en(f_en),
        .set_stb(f_set_stb), .set_hours(f_set_hours), .set_mins(f_set_mins), .set_secs(f_set_secs),
        .set_ack(f_set_ack), .set_err(f_set_err),
        .alarm_wr(1'b0), .alarm_hours(4'd0), .alarm_mins(8'd0),
        .alarm_secs(8'd0), .alarm_en(1'b0), .alarm_clr(1'b0),
        .hours(f_hours), .mins(f_mins), .secs(f_secs),
        .sec_tick(f_sec_tick), .day_tick(f_day_tick), .alarm_irq(f_alarm_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitors: every presented event must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (!rst && (sec_tick || set_ack || set_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_unexpected: got kind %b at cycle %0d expected no event",
                         {sec_tick, set_ack, set_err}, cyc);
            end else begin
                me = q.pop_front();
                check("main_event",
                      {cyc, sec_tick, set_ack, set_err, hours, mins, secs, day_tick, alarm_irq},
                      {me.cyc, me.kind, me.h, me.m, me.s, me.day, me.irq});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (f_sec_tick || f_set_ack || f_set_err)) begin
            if (fq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL free_unexpected: got kind %b at cycle %0d expected no event",
                         {f_sec_tick, f_set_ack, f_set_err}, cyc);
            end else begin
                fe = fq.pop_front();
                check("free_event",
                      {cyc, f_sec_tick, f_set_ack, f_set_err, 12'd0, f_hours, f_mins, f_secs,
                       f_day_tick, f_alarm_irq},
                      {fe.cyc, fe.kind, fe.h, fe.m, fe.s, fe.day, fe.irq});
            end
        end
    end

    task automatic expect_ev(input bit free, input int d, input logic [2:0] k,
                             input logic [15:0] h, input logic [7:0] m, input logic [7:0] s,
                             input logic day, input logic irq);
        ev_t e;
        e.cyc = cyc + d; e.kind = k; e.h = h; e.m = m; e.s = s; e.day = day; e.irq = irq;
        if (free) fq.push_back(e);
        else      q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_set(input logic [15:0] h, input logic [7:0] m, input logic [7:0] s);
        set_hours = h; set_mins = m; set_secs = s; set_stb = 1'b1;
        @(negedge clk);
        set_stb = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; set_stb = 1'b0; alarm_wr = 1'b0; alarm_en = 1'b0; alarm_clr = 1'b0;
        set_hours = '0; set_mins = '0; set_secs = '0;
        alarm_hours = '0; alarm_mins = '0; alarm_secs = '0;
        f_en = 1'b0; f_set_stb = 1'b0; f_set_hours = '0; f_set_mins = '0; f_set_secs = '0;
        run(3);
        check("reset_state", {hours, mins, secs, sec_tick, day_tick, set_ack, set_err, alarm_irq}, '0);

        // Prescale: one tick per 4 enabled cycles
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 3; k++) expect_ev(0, 4 * k, K_TICK, 0, 0, 8'(k), 0, 0);
        run(12);
        en = 1'b0;
        run(10);
        check("freeze_time", {hours, mins, secs}, {16'd0, 8'd0, 8'd3});

        // Freeze with pcnt=2: only two more enabled cycles are needed for the next tick
        en = 1'b1;
        expect_ev(0, 14, K_TICK, 0, 0, 4, 0, 0);
        run(2); en = 1'b0; run(10); en = 1'b1; run(2); en = 1'b0;

        // Out-of-range loads are rejected, time stays 00:00:04
        expect_ev(0, 1, K_ERR, 0, 0, 4, 0, 0); pulse_set(10, 60, 0);
        expect_ev(0, 1, K_ERR, 0, 0, 4, 0, 0); pulse_set(24, 0, 0);
        expect_ev(0, 1, K_ERR, 0, 0, 4, 0, 0); pulse_set(0, 0, 60);

        // Carry through midnight
        expect_ev(0, 1, K_ACK, 23, 59, 58, 0, 0); pulse_set(23, 59, 58);
        en = 1'b1;
        expect_ev(0, 4, K_TICK, 23, 59, 59, 0, 0);
        expect_ev(0, 8, K_TICK, 0, 0, 0, 1, 0);
        run(8); en = 1'b0;

        // Load on the tick cycle wins and restarts the prescaler
        en = 1'b1; run(3);
        expect_ev(0, 1, K_ACK, 10, 30, 0, 0, 0); pulse_set(10, 30, 0);
        expect_ev(0, 4, K_TICK, 10, 30, 1, 0, 0);
        run(4); en = 1'b0;

        // Alarm at 00:00:05
        expect_ev(0, 1, K_ACK, 0, 0, 0, 0, 0); pulse_set(0, 0, 0);
        alarm_wr = 1'b1; alarm_hours = 0; alarm_mins = 0; alarm_secs = 5; alarm_en = 1'b1;
        run(1); alarm_wr = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 5; k++) expect_ev(0, 4 * k, K_TICK, 0, 0, 8'(k), 0, logic'(k == 5));
        run(20); en = 1'b0;
        alarm_clr = 1'b1; run(1); alarm_clr = 1'b0;
        check("alarm_clr", 96'(alarm_irq), 96'(0));

        // alarm_en=0 suppresses a match
        alarm_en = 1'b0;
        expect_ev(0, 1, K_ACK, 0, 0, 4, 0, 0); pulse_set(0, 0, 4);
        en = 1'b1; expect_ev(0, 4, K_TICK, 0, 0, 5, 0, 0); run(4); en = 1'b0;

        // Match and clear in the same cycle: the match wins
        alarm_en = 1'b1;
        expect_ev(0, 1, K_ACK, 0, 0, 4, 0, 0); pulse_set(0, 0, 4);
        en = 1'b1; run(3);
        alarm_clr = 1'b1; expect_ev(0, 1, K_TICK, 0, 0, 5, 0, 1);
        run(1); alarm_clr = 1'b0; en = 1'b0;
        alarm_en = 1'b0; run(5);
        check("alarm_en_keeps_flag", 96'(alarm_irq), 96'(1));
        alarm_clr = 1'b1; run(1); alarm_clr = 1'b0;
        check("alarm_clr_again", 96'(alarm_irq), 96'(0));
        alarm_en = 1'b1;

        // Free-running 4-bit hours wrap from 15:59:59
        f_set_hours = 15; f_set_mins = 59; f_set_secs = 59; f_set_stb = 1'b1;
        expect_ev(1, 1, K_ACK, 15, 59, 59, 0, 0);
        run(1); f_set_stb = 1'b0;
        f_en = 1'b1; expect_ev(1, 4, K_TICK, 0, 0, 0, 1, 0); run(4); f_en = 1'b0;

        // Asynchronous reset at 01:02:03 with pcnt=2, a load pending
        expect_ev(0, 1, K_ACK, 1, 2, 2, 0, 0); pulse_set(1, 2, 2);
        en = 1'b1; expect_ev(0, 4, K_TICK, 1, 2, 3, 0, 0); run(6);
        check("pre_reset_time", {hours, mins, secs}, {16'd1, 8'd2, 8'd3});
        set_hours = 5; set_mins = 5; set_secs = 5; set_stb = 1'b1;
        rst = 1'b1;
        #1;
        check("async_reset", {hours, mins, secs, sec_tick, day_tick, set_ack, set_err, alarm_irq}, '0);
        check("async_reset_free", {f_hours, f_mins, f_secs, f_sec_tick, f_day_tick}, '0);
        run(1);
        set_stb = 1'b0; rst = 1'b0; en = 1'b1;
        expect_ev(0, 4, K_TICK, 0, 0, 1, 0, 0);
        run(4); en = 1'b0;

        for (int i = 0; i < 20 && (q.size() + fq.size()) != 0; i++) @(negedge clk);
        run(2);
        check("queue_drain", 96'(q.size() + fq.size()), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
